// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic lab blocks.
//   state_e   : controller states of the serial subtractor
//   cnt_width : bit-counter width for a given operand width
//   ModeSub / ModeAdd : operation encodings for the optional mode input
package serial_arith_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic ModeSub = 1'b0;
  localparam logic ModeAdd = 1'b1;

  // Counter must index bits 0..width-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: computes a_i - b_i - bin_i.
//   a_i    : minuend bit
//   b_i    : subtrahend bit
//   bin_i  : borrow in
//   d_o    : difference bit
//   bout_o : borrow out
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b, one bit per clock, LSB first, through a single
// full-subtractor cell and a borrow flip-flop. Start/done handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only in idle
//   a, b       : operands, captured when start is accepted
//   mode       : (only with SERIAL_ADDSUB_MODE_EN) 0 = subtract, 1 = add
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when diff/borrow_out/overflow are updated
//   diff       : result modulo 2^WIDTH
//   borrow_out : unsigned borrow (a < b); in add mode the inverted carry-out
//   overflow   : two's complement overflow of the operation
// Optional feature macro: SERIAL_ADDSUB_MODE_EN adds the mode input.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDSUB_MODE_EN
  input  logic             mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, a_sr_d;
  logic [WIDTH-1:0]  b_sr_q, b_sr_d;
  // Holds the bits finished so far; the bit in flight completes the WIDTH-bit result.
  logic [WIDTH-2:0]  res_q, res_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              borrow_q, borrow_d;
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_out_q, borrow_out_d;
  logic              overflow_q, overflow_d;
`ifdef SERIAL_ADDSUB_MODE_EN
  logic              add_q, add_d;
`endif

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] res_shift;
  logic             ovf_now;
  logic             add_cap;

  full_subtractor u_cell (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .bin_i  (borrow_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  assign res_shift = {cell_d, res_q};

`ifdef SERIAL_ADDSUB_MODE_EN
  assign add_cap = (mode == ModeAdd);
  // Add is a - ~b - 1 with the borrow preset; the MSBs kept are the original operands.
  assign ovf_now = add_q ? (~(a_msb_q ^ b_msb_q) & (a_msb_q ^ cell_d))
                         : ((a_msb_q ^ b_msb_q) & (a_msb_q ^ cell_d));
`else
  assign add_cap = ModeSub;
  assign ovf_now = (a_msb_q ^ b_msb_q) & (a_msb_q ^ cell_d);
`endif

  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    res_d        = res_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;
`ifdef SERIAL_ADDSUB_MODE_EN
    add_d        = add_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = add_cap ? ~b : b;
          borrow_d = add_cap;
          res_d    = '0;
          cnt_d    = '0;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`ifdef SERIAL_ADDSUB_MODE_EN
          add_d    = add_cap;
`endif
          state_d  = StRun;
        end
      end
      StRun: begin
        res_d    = res_shift[WIDTH-1:1];
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          cnt_d        = '0;
          diff_d       = res_shift;
          borrow_out_d = cell_bout;
          overflow_d   = ovf_now;
          state_d      = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_MODE_EN
      add_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
`ifdef SERIAL_ADDSUB_MODE_EN
      add_q        <= add_d;
`endif
    end
  end

  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start_r;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
  logic       overflow;
`ifdef SERIAL_ADDSUB_MODE_EN
  logic       mode_r;
`endif

  int total = 0;
  int bad   = 0;

  serial_subtractor #(
    .WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_r),
`ifdef SERIAL_ADDSUB_MODE_EN
    .mode       (mode_r),
`endif
    .a          (a_r),
    .b          (b_r),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle start, then follow the operation to its done pulse with a bounded wait.
  task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                    input logic eb, input logic eo, input string tag);
    int n;
    int bc;
    logic stable;
    logic [7:0] prev;
    @(negedge clk);
    a_r     = av;
    b_r     = bv;
    start_r = 1'b1;
    prev    = diff;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    a_r     = ~av;
    b_r     = av ^ bv;
    n       = 0;
    bc      = 0;
    stable  = 1'b1;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) bc++;
      if (diff !== prev) stable = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " done_latency"}, n, 8);
    check({tag, " busy_cycles"}, bc, 8);
    check({tag, " diff_held"}, {31'd0, stable}, 1);
    check({tag, " diff"}, {24'd0, diff}, {24'd0, ed});
    check({tag, " borrow_out"}, {31'd0, borrow_out}, {31'd0, eb});
    check({tag, " overflow"}, {31'd0, overflow}, {31'd0, eo});
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, {31'd0, done}, 0);
  endtask

  initial begin
    int first_done;
    int second_done;
    int ndone;
    logic [7:0] d_first;
    logic [7:0] d_second;

    rst_n   = 1'b0;
    start_r = 1'b0;
    a_r     = 8'd0;
    b_r     = 8'd0;
`ifdef SERIAL_ADDSUB_MODE_EN
    mode_r  = 1'b0;
`endif
    #3;
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset diff", {24'd0, diff}, 0);
    check("reset borrow_out", {31'd0, borrow_out}, 0);
    check("reset overflow", {31'd0, overflow}, 0);
    #20;
    rst_n = 1'b1;

    op(8'd100, 8'd37, 8'd63, 1'b0, 1'b0, "sub 100-37");
    op(8'd5, 8'd9, 8'hFC, 1'b1, 1'b0, "sub 5-9");
    op(8'h80, 8'd1, 8'h7F, 1'b0, 1'b1, "sub 80-1");
    op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "sub 7f-ff");

    // start held high; operands change every cycle, only idle-cycle values are captured.
    first_done  = -1;
    second_done = -1;
    ndone       = 0;
    d_first     = 8'd0;
    d_second    = 8'd0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      start_r = 1'b1;
      if (e == 0) begin
        a_r = 8'd10;
        b_r = 8'd3;
      end else if (e == 10) begin
        a_r = 8'd50;
        b_r = 8'd20;
      end else begin
        a_r = 8'(e * 37);
        b_r = 8'(e * 11 + 1);
      end
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (first_done < 0) begin
          first_done = e;
          d_first    = diff;
        end else if (second_done < 0) begin
          second_done = e;
          d_second    = diff;
        end
      end
    end
    @(negedge clk);
    start_r = 1'b0;
    check("held first_done_edge", first_done, 8);
    check("held first_diff", {24'd0, d_first}, 7);
    check("held second_done_edge", second_done, 18);
    check("held second_diff", {24'd0, d_second}, 30);
    check("held done_count", ndone, 2);
    @(posedge clk);
    #1;

    // Abort 200-55 with reset while bit 4 is pending.
    @(negedge clk);
    a_r     = 8'd200;
    b_r     = 8'd55;
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    check("pre-abort busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 0);
    check("abort done", {31'd0, done}, 0);
    check("abort diff", {24'd0, diff}, 0);
    check("abort borrow_out", {31'd0, borrow_out}, 0);
    check("abort overflow", {31'd0, overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    check("abort no_done", ndone, 0);
    op(8'd200, 8'd55, 8'd145, 1'b0, 1'b0, "sub 200-55");

`ifdef SERIAL_ADDSUB_MODE_EN
    mode_r = 1'b1;
    op(8'd100, 8'd37, 8'd137, 1'b1, 1'b1, "add 100+37");
    op(8'd200, 8'd100, 8'd44, 1'b0, 1'b0, "add 200+100");
    mode_r = 1'b0;
    op(8'd100, 8'd37, 8'd63, 1'b0, 1'b0, "sub again 100-37");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes a - b one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Inverse-direction counterpart of the team's combinational full-adder lab block.
- Sits in the arithmetic lab datapath, driven by a start/done handshake from a controller or bench.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend, captured when start is accepted.
- b  input  WIDTH  subtrahend, captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  result a - b, modulo 2^WIDTH.
- borrow_out  output  1  unsigned borrow; 1 when a < b.
- overflow  output  1  signed (two's complement) overflow of a - b.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, immediate, no clock needed) sets:
  - state = IDLE;
  - busy = 0, done = 0;
  - diff = 0, borrow_out = 0, overflow = 0;
  - internal shift registers, bit counter and borrow FF = 0.
- FSM states:
  - IDLE, on an edge with start=1: load a and b into shift registers, clear borrow FF, set counter = 0, go to RUN.
  - RUN, each edge:
    - full_subtractor(a_sr[0], b_sr[0], borrow) yields d and bout;
    - d shifts into the MSB of the result register; a_sr and b_sr shift right;
    - borrow <= bout; counter increments.
  - RUN, on the edge that processes bit WIDTH-1 (counter == WIDTH-1): go to DONE. On that same edge:
    - diff <= final result;
    - borrow_out <= bout;
    - overflow <= (a_msb ^ b_msb) & (a_msb ^ d_msb), using the captured operand MSBs.
  - DONE: done = 1 for exactly one cycle, then unconditionally go to IDLE.
- Latency:
  - start sampled at edge E0; busy = 1 from E0 through E(WIDTH).
  - done = 1 in the cycle after edge E(WIDTH), i.e. WIDTH+1 edges after acceptance.
  - Back-to-back throughput is one operation per WIDTH+2 cycles.
- start is ignored in RUN and DONE. No queuing: a request held high through DONE is accepted in the following IDLE cycle.
- diff, borrow_out and overflow hold their last values until the next completion. They do not change during RUN; the result register is separate from the diff output.
- a and b may change freely after acceptance without affecting the result.
- Reset mid-RUN aborts the operation: outputs return to reset values and no done pulse is issued.
- Counter width is $clog2(WIDTH). The compare against WIDTH-1 must be correct for non-power-of-two WIDTH.

Optional Feature:
- Macro: SERIAL_ADDSUB_MODE_EN.
- Defined:
  - Adds port mode (input, 1), captured with the operands: 0 = subtract, 1 = add.
  - In add mode, b is inverted bitwise at capture, the borrow FF is preset to 1, and the cell output is used as a + b.
  - borrow_out then reports the inverted carry-out (carry = ~borrow_out).
  - overflow uses the add rule: (a_msb ~^ b_msb) & (a_msb ^ d_msb).
- Undefined: the port is absent and the block is subtract-only. Latency is identical in both builds.

Decomposition:
- Package serial_arith_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - localparam function for the counter width;
  - mode encodings MODE_SUB = 0, MODE_ADD = 1.
- One sub-module, full_subtractor (a, b, bin -> d, bout), combinational:
  - d = a ^ b ^ bin;
  - bout = (~a & b) | (~(a ^ b) & bin).

Test Plan:
- WIDTH=8, a=100, b=37, one-cycle start -> busy for 9 edges (E0 through E8); done pulse one cycle later (after E8); diff=63, borrow_out=0, overflow=0.
- a=5, b=9 -> diff=8'hFC, borrow_out=1, overflow=0.
- a=8'h80 (-128), b=1 -> diff=8'h7F, overflow=1, borrow_out=0.
- start held high continuously with changing a/b -> operands re-sampled only in IDLE; exactly one done per WIDTH+2 cycles; results match the operands captured at each acceptance.
- rst_n pulsed low at RUN bit 4 of a=200, b=55 -> outputs 0 immediately with no clock; no done; a fresh start afterwards gives diff=145.
- SERIAL_ADDSUB_MODE_EN builds: mode=1, a=100, b=37 -> diff=137, borrow_out=1 (no carry), overflow=1.
